// File: rtl/count_display_if.sv
// Bundles the count input and display/wrap outputs of count_display.
// The slave modport is the display block; the master modport is whoever drives count.
interface count_display_if;
    logic [3:0] count;
    logic [6:0] seg;
    logic [1:0] an;
    logic       wrap;
    logic [7:0] wrap_cnt;

    modport master (
        output count,
        input  seg,
        input  an,
        input  wrap,
        input  wrap_cnt
    );

    modport slave (
        input  count,
        output seg,
        output an,
        output wrap,
        output wrap_cnt
    );
endinterface

// File: rtl/count_display.sv
// Two-digit multiplexed 7-segment driver for a 4-bit counter, with wrap detection and a saturating wrap count.
// Optional macro LEADING_ZERO_BLANK_EN blanks the tens digit when it is zero.
module count_display #(
    parameter int SCAN_DIV = 4
) (
    input  logic            clk,
    input  logic            rst,
    count_display_if.slave  bus
);

    typedef enum logic [1:0] {ONES, BLANK0, TENS, BLANK1} state_t;

    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

    state_t     state;
    logic [3:0] cnt_q;
    logic [7:0] div;
    logic [6:0] seg_q;
    logic [1:0] an_q;
    logic       wrap_q;
    logic [7:0] wrap_cnt_q;
    logic       tens;
    logic [3:0] ones;
    logic [6:0] ones_seg;
    logic [6:0] tens_seg;
    logic       wrap_evt;

    function automatic logic [6:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    encode = 7'h3F;
            4'd1:    encode = 7'h06;
            4'd2:    encode = 7'h5B;
            4'd3:    encode = 7'h4F;
            4'd4:    encode = 7'h66;
            4'd5:    encode = 7'h6D;
            4'd6:    encode = 7'h7D;
            4'd7:    encode = 7'h07;
            4'd8:    encode = 7'h7F;
            4'd9:    encode = 7'h6F;
            default: encode = 7'h00;
        endcase
    endfunction

    assign tens     = (cnt_q >= 4'd10);
    assign ones     = tens ? (cnt_q - 4'd10) : cnt_q;
    assign ones_seg = encode(ones);
`ifdef LEADING_ZERO_BLANK_EN
    assign tens_seg = tens ? 7'h06 : 7'h00;
`else
    assign tens_seg = encode({3'b000, tens});
`endif

    // A wrap is the previous sample at 15 followed by a 0 arriving now
    assign wrap_evt = (cnt_q == 4'd15) && (bus.count == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= 4'd0;
            wrap_q     <= 1'b0;
            wrap_cnt_q <= 8'd0;
        end else begin
            cnt_q  <= bus.count;
            wrap_q <= wrap_evt;
            if (wrap_evt && (wrap_cnt_q != 8'hFF))
                wrap_cnt_q <= wrap_cnt_q + 8'd1;
        end
    end

    // Scan FSM; seg/an are loaded on the state-change edge so a digit is frozen for its whole slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BLANK1;
            div   <= 8'd0;
            seg_q <= 7'h00;
            an_q  <= 2'b00;
        end else begin
            case (state)
                ONES: begin
                    if (div == DIV_LAST) begin
                        state <= BLANK0;
                        div   <= 8'd0;
                        seg_q <= 7'h00;
                        an_q  <= 2'b00;
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                BLANK0: begin
                    state <= TENS;
                    div   <= 8'd0;
                    seg_q <= tens_seg;
                    an_q  <= 2'b10;
                end
                TENS: begin
                    if (div == DIV_LAST) begin
                        state <= BLANK1;
                        div   <= 8'd0;
                        seg_q <= 7'h00;
                        an_q  <= 2'b00;
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                default: begin
                    state <= ONES;
                    div   <= 8'd0;
                    seg_q <= ones_seg;
                    an_q  <= 2'b01;
                end
            endcase
        end
    end

    assign bus.seg      = seg_q;
    assign bus.an       = an_q;
    assign bus.wrap     = wrap_q;
    assign bus.wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_count_display.sv
// Directed self-checking bench for count_display (SCAN_DIV=4); expectations queue up in a scoreboard
// and are popped against the DUT one time unit after each rising edge.
module tb_count_display;

    localparam int SCAN_DIV = 4;
    localparam int PERIOD   = 2 * SCAN_DIV + 2;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] TENS_ZERO = 8'h00;
`else
    localparam logic [7:0] TENS_ZERO = 8'h3F;
`endif

    localparam int SEL_SEG  = 0;
    localparam int SEL_AN   = 1;
    localparam int SEL_WRAP = 2;
    localparam int SEL_WCNT = 3;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    count_display_if bus ();

    count_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   exp_wraps = 0;

    // Position inside the scan period, 0 = first ONES cycle after reset release
    function automatic int phase();
        return (cyc - 1) % PERIOD;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic waitPhase(input int target);
        do tick(); while (phase() != target);
    endtask

    task automatic applyStimulus(input logic [3:0] c);
        bus.count = c;
    endtask

    task automatic expectOut(input string tag, input int sel, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        logic [7:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                SEL_SEG:  obs = {1'b0, bus.seg};
                SEL_AN:   obs = {6'b0, bus.an};
                SEL_WRAP: obs = {7'b0, bus.wrap};
                default:  obs = bus.wrap_cnt;
            endcase
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic showDigits(input logic [3:0] c, input logic [7:0] ones_s, input logic [7:0] tens_s);
        applyStimulus(c);
        waitPhase(PERIOD - 1);
        waitPhase(0);
        expectOut($sformatf("ones_seg_%0d", c), SEL_SEG, ones_s);
        expectOut($sformatf("ones_an_%0d", c), SEL_AN, 8'h01);
        checkOutput();
        waitPhase(SCAN_DIV + 1);
        expectOut($sformatf("tens_seg_%0d", c), SEL_SEG, tens_s);
        expectOut($sformatf("tens_an_%0d", c), SEL_AN, 8'h02);
        checkOutput();
    endtask

    task automatic expectWrap(input string tag, input logic w);
        expectOut({tag, "_wrap"}, SEL_WRAP, {7'b0, w});
        expectOut({tag, "_wcnt"}, SEL_WCNT, 8'(exp_wraps));
        checkOutput();
    endtask

    initial begin
        int p;
        logic [7:0] exp_an;
        $display("[TB] start, SCAN_DIV=%0d", SCAN_DIV);

        // Reset state, checked before any clock edge and again with clocks running
        applyStimulus(4'd7);
        #2;
        expectOut("rst_seg", SEL_SEG, 8'h00);
        expectOut("rst_an", SEL_AN, 8'h00);
        expectOut("rst_wrap", SEL_WRAP, 8'h00);
        expectOut("rst_wcnt", SEL_WCNT, 8'h00);
        checkOutput();
        tick();
        tick();
        expectOut("rst_hold_an", SEL_AN, 8'h00);
        expectOut("rst_hold_seg", SEL_SEG, 8'h00);
        checkOutput();

        rst = 1'b1;
        cyc = 0;

        // Scan timing with count=7
        for (int k = 0; k < 3 * PERIOD; k++) begin
            tick();
            p = phase();
            if (p < SCAN_DIV)
                exp_an = 8'h01;
            else if (p > SCAN_DIV && p < PERIOD - 1)
                exp_an = 8'h02;
            else
                exp_an = 8'h00;
            expectOut($sformatf("scan_an_c%0d", k), SEL_AN, exp_an);
            if (exp_an == 8'h00)
                expectOut($sformatf("scan_blank_c%0d", k), SEL_SEG, 8'h00);
            else if (exp_an == 8'h02)
                expectOut($sformatf("scan_tens_c%0d", k), SEL_SEG, TENS_ZERO);
            else if (k >= PERIOD)
                expectOut($sformatf("scan_ones_c%0d", k), SEL_SEG, 8'h07);
            checkOutput();
        end

        // Two-digit and single-digit values
        showDigits(4'd13, 8'h4F, 8'h06);
        showDigits(4'd5,  8'h6D, TENS_ZERO);
        showDigits(4'd9,  8'h6F, TENS_ZERO);
        showDigits(4'd0,  8'h3F, TENS_ZERO);
        showDigits(4'd10, 8'h3F, 8'h06);

        // 15, then a mid-slot change must not disturb the frozen ones digit
        applyStimulus(4'd15);
        waitPhase(PERIOD - 1);
        waitPhase(0);
        expectOut("ones_seg_15", SEL_SEG, 8'h6D);
        checkOutput();
        waitPhase(SCAN_DIV + 1);
        expectOut("tens_seg_15", SEL_SEG, 8'h06);
        checkOutput();
        waitPhase(0);
        applyStimulus(4'd3);
        waitPhase(SCAN_DIV - 1);
        expectOut("hold_seg_15", SEL_SEG, 8'h6D);
        expectOut("hold_an_15", SEL_AN, 8'h01);
        checkOutput();

        // Wrap detection: 14,15,0,1 pulses once; 14->0 and 15->15 do not
        expectWrap("pre_wrap", 1'b0);
        applyStimulus(4'd14); tick();
        applyStimulus(4'd15); tick();
        expectWrap("w_15", 1'b0);
        applyStimulus(4'd0);  tick();
        exp_wraps = 1;
        expectWrap("w_0", 1'b1);
        applyStimulus(4'd1);  tick();
        expectWrap("w_1", 1'b0);
        applyStimulus(4'd14); tick();
        applyStimulus(4'd0);  tick();
        expectWrap("w_14_0", 1'b0);
        tick();
        expectWrap("w_0_0", 1'b0);
        applyStimulus(4'd15); tick();
        tick();
        expectWrap("w_15_15", 1'b0);

        // Saturation of the wrap counter
        for (int i = 0; i < 300; i++) begin
            applyStimulus(4'd15); tick();
            applyStimulus(4'd0);  tick();
            if (exp_wraps < 255)
                exp_wraps++;
            expectWrap($sformatf("sat_%0d", i), 1'b1);
        end
        expectOut("sat_final", SEL_WCNT, 8'd255);
        checkOutput();

        // Reset in the middle of a tens slot with count=12
        applyStimulus(4'd12);
        waitPhase(PERIOD - 1);
        waitPhase(SCAN_DIV + 1);
        expectOut("pre_rst_tens", SEL_SEG, 8'h06);
        checkOutput();
        #3;
        rst = 1'b0;
        #1;
        exp_wraps = 0;
        expectOut("mid_rst_seg", SEL_SEG, 8'h00);
        expectOut("mid_rst_an", SEL_AN, 8'h00);
        expectOut("mid_rst_wcnt", SEL_WCNT, 8'h00);
        checkOutput();
        tick();
        rst = 1'b1;
        cyc = 0;
        tick();
        expectOut("rel_an", SEL_AN, 8'h01);
        checkOutput();
        waitPhase(PERIOD - 1);
        waitPhase(0);
        expectOut("rel_ones_seg", SEL_SEG, 8'h5B);
        expectOut("rel_ones_an", SEL_AN, 8'h01);
        expectOut("rel_wcnt", SEL_WCNT, 8'h00);
        checkOutput();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
